mem_stage: RTL

- Memory-access pipeline stage between the execute stage and write-back in the 5-stage MIPS core.
- Registers the execute-to-memory bus under stall control.
- Takes load data from the synchronous data SRAM, which returns data one cycle after the address issued in execute.
- Performs byte/halfword/word extraction with sign or zero extension, then drives the write-back bus and the register-file forwarding bus.

---
 rtl/mem_stage.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory-access stage: pipeline register, load-data hold and load extraction
module mem_stage #(
    parameter int EX_TO_MEM_WD = 81,
    parameter int MEM_TO_WB_WD = 70,
    parameter int MEM_TO_RF_WD = 38,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    logic [EX_TO_MEM_WD-1:0] bus_q;
    logic [31:0]             rdata_hold_q;
    logic                    hold_valid_q;

    logic        stall_mem;
    logic        stall_wb;
    logic        bus_holds;

    logic [4:0]  mem_op;
    logic [31:0] mem_pc;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
    logic [1:0]  addr_lo;

    logic [31:0] rdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_data;
    logic [31:0] mem_result;

    // Byte-enable fields and unrelated stall bits are consumed upstream.
    logic unused_ok;
    assign unused_ok = ^{bus_q[43:39], stall};

    assign stall_mem = stall[3];
    assign stall_wb  = stall[4];
    assign bus_holds = stall_mem & stall_wb;

    // Execute-to-memory pipeline register: bubble when stopped but write-back drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q <= '0;
        end else if (stall_mem && !stall_wb) begin
            bus_q <= '0;
        end else if (!stall_mem) begin
            bus_q <= ex_to_mem_bus;
        end
    end

    // Freeze the first-cycle SRAM data while the instruction is held, since the SRAM moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_q <= '0;
            hold_valid_q <= 1'b0;
        end else if (!bus_holds) begin
            hold_valid_q <= 1'b0;
        end else if (!hold_valid_q) begin
            rdata_hold_q <= data_sram_rdata;
            hold_valid_q <= 1'b1;
        end
    end

    assign mem_op     = bus_q[80:76];
    assign mem_pc     = bus_q[75:44];
    assign sel_rf_res = bus_q[38];
    assign rf_we      = bus_q[37];
    assign rf_waddr   = bus_q[36:32];
    assign ex_result  = bus_q[31:0];
    assign addr_lo    = ex_result[1:0];

    assign rdata = hold_valid_q ? rdata_hold_q : data_sram_rdata;

    // Select the addressed byte and halfword lane; halfword ignores a[0].
    always_comb begin
        rbyte = rdata[7:0];
        case (addr_lo)
            2'd0: rbyte = rdata[7:0];
            2'd1: rbyte = rdata[15:8];
            2'd2: rbyte = rdata[23:16];
            2'd3: rbyte = rdata[31:24];
            default: rbyte = rdata[7:0];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Extend the selected lane by load type; word and non-load pass rdata through.
    always_comb begin
        load_data = rdata;
        case (mem_op)
            5'b10000: load_data = {{24{rbyte[7]}}, rbyte};
            5'b01000: load_data = {24'd0, rbyte};
            5'b00100: load_data = {{16{rhalf[15]}}, rhalf};
            5'b00010: load_data = {16'd0, rhalf};
            default:  load_data = rdata;
        endcase
    end

    assign mem_result = sel_rf_res ? load_data : ex_result;

    assign mem_to_wb_bus = {mem_pc, rf_we, rf_waddr, mem_result};
    assign mem_to_rf_bus = {rf_we, rf_waddr, mem_result};

endmodule
